// File: rtl/fmc_adc_trig_pkg.sv
// FMC-ADC trigger scheduler shared definitions.
// Source bit map and scheduler state encoding.
package fmc_adc_trig_pkg;

  localparam int c_TRIG_EXT    = 0;
  localparam int c_TRIG_SW     = 1;
  localparam int c_TRIG_TIME   = 2;
  localparam int c_TRIG_AUX    = 3;
  localparam int c_TRIG_CH1    = 4;
  localparam int c_TRIG_CH2    = 5;
  localparam int c_TRIG_CH3    = 6;
  localparam int c_TRIG_CH4    = 7;
  localparam int c_NB_TRIG_SRC = 8;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    HOLDOFF
  } t_trig_sched_state;

endpackage

// File: rtl/fmc_adc_trig_dly.sv
// Loadable down-counter for the external trigger delay.
// fire is high in the cycle the count reaches 1.
module fmc_adc_trig_dly #(
  parameter int unsigned g_DLY_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [g_DLY_WIDTH-1:0] value,
  input  logic                   cancel,
  output logic                   busy,
  output logic                   fire
);

  localparam logic [g_DLY_WIDTH-1:0] c_ONE = g_DLY_WIDTH'(1);

  logic [g_DLY_WIDTH-1:0] cnt;

  assign busy = (cnt != '0);
  assign fire = (cnt == c_ONE);

  // Count down a captured delay; cancel wins over a new load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cancel) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (busy) begin
      cnt <= cnt - c_ONE;
    end
  end

endmodule

// File: rtl/fmc_adc_trig_sched.sv
// FMC-ADC trigger scheduler: masks, delays and holds off
// trigger sources, and counts accepted/missed triggers.
module fmc_adc_trig_sched
  import fmc_adc_trig_pkg::*;
#(
  parameter int unsigned g_DLY_WIDTH     = 32,
  parameter int unsigned g_HOLDOFF_WIDTH = 32,
  parameter int unsigned g_CNT_WIDTH     = 16
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_i,
  input  logic [c_NB_TRIG_SRC-1:0]   trig_src_i,
  input  logic [c_NB_TRIG_SRC-1:0]   trig_en_i,
  input  logic [g_DLY_WIDTH-1:0]     ext_dly_i,
  input  logic [g_HOLDOFF_WIDTH-1:0] holdoff_i,
  input  logic                       armed_i,
  input  logic                       acq_stop_i,
  input  logic                       cnt_clr_i,
  output logic                       trig_o,
  output logic [c_NB_TRIG_SRC-1:0]   trig_src_o,
  output logic [g_CNT_WIDTH-1:0]     trig_cnt_o,
  output logic [g_CNT_WIDTH-1:0]     miss_cnt_o,
  output logic                       ext_dly_busy_o
);

  localparam logic [g_HOLDOFF_WIDTH-1:0] c_HO_ONE =
    g_HOLDOFF_WIDTH'(1);
  localparam logic [g_CNT_WIDTH-1:0] c_CNT_ONE =
    g_CNT_WIDTH'(1);

  t_trig_sched_state            state;
  logic [g_HOLDOFF_WIDTH-1:0]   hold_cnt;
  logic [c_NB_TRIG_SRC-1:0]     req;
  logic                         ext;
  logic                         ext_now;
  logic                         dly_load;
  logic                         dly_busy;
  logic                         dly_fire;
  logic                         ext_drop;
  logic                         acc;
  logic                         trig_inc;
  logic                         miss_inc;

  assign ext      = trig_src_i[c_TRIG_EXT] & trig_en_i[c_TRIG_EXT];
  assign ext_now  = ext & ~dly_busy & (ext_dly_i == '0);
  assign dly_load = ext & ~dly_busy & (ext_dly_i != '0);
  assign ext_drop = ext & dly_busy;

  fmc_adc_trig_dly #(
    .g_DLY_WIDTH (g_DLY_WIDTH)
  ) u_dly (
    .clk    (sys_clk_i),
    .rst    (sys_rst_i),
    .load   (dly_load),
    .value  (ext_dly_i),
    .cancel (acq_stop_i),
    .busy   (dly_busy),
    .fire   (dly_fire)
  );

  assign ext_dly_busy_o = dly_busy;

  // Merge enabled sources with the (possibly delayed) ext request
  always_comb begin
    req = trig_src_i & trig_en_i;
    req[c_TRIG_EXT] = ext_now | dly_fire;
  end

  // Accept/miss events feeding the statistics counters
  always_comb begin
    acc      = (state == READY) & (|req);
    trig_inc = acc & ~acq_stop_i;
    miss_inc = ~acq_stop_i &
               (((state == HOLDOFF) & (|req)) |
                (ext_drop & armed_i));
  end

  // Scheduler FSM with registered trigger pulse and source latch
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      trig_o     <= 1'b0;
      trig_src_o <= '0;
    end else begin
      trig_o <= 1'b0;
      if (acq_stop_i) begin
        state    <= IDLE;
        hold_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (armed_i) state <= READY;
          end
          READY: begin
            if (|req) begin
              trig_o     <= 1'b1;
              trig_src_o <= req;
              if (holdoff_i != '0) begin
                hold_cnt <= holdoff_i;
                state    <= HOLDOFF;
              end
            end else if (!armed_i) begin
              state <= IDLE;
            end
          end
          HOLDOFF: begin
            hold_cnt <= hold_cnt - c_HO_ONE;
            if (hold_cnt == c_HO_ONE)
              state <= armed_i ? READY : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Saturating statistics counters; clear beats increment
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      trig_cnt_o <= '0;
      miss_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      trig_cnt_o <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (trig_inc && trig_cnt_o != '1)
        trig_cnt_o <= trig_cnt_o + c_CNT_ONE;
      if (miss_inc && miss_cnt_o != '1)
        miss_cnt_o <= miss_cnt_o + c_CNT_ONE;
    end
  end

endmodule

// File: doc/fmc_adc_trig_sched.md
Name: fmc_adc_trig_sched

Overview:
Trigger scheduler for the FMC-ADC 100MS acquisition core. It sits between the raw trigger sources (external input, software, time trigger, Wishbone trig-in, channel thresholds CH1..CH4) and the acquisition FSM. It applies the enable mask and the external-trigger delay, enforces a holdoff between accepted triggers, and issues one qualified trigger pulse per accepted event. It also records which sources fired and keeps accepted/missed statistics for the CSR.

Parameters:
g_DLY_WIDTH, 32, width of the external-trigger delay counter (EXT_TRIG_DLY register).
g_HOLDOFF_WIDTH, 32, width of the holdoff counter.
g_CNT_WIDTH, 16, width of the accepted and missed trigger counters.

Ports:
sys_clk_i  in  1  system clock, 125 MHz.
sys_rst_i  in  1  asynchronous, active-high reset.
trig_src_i  in  8  single-cycle source pulses, already synchronised to sys_clk_i. Bit 0 ext, 1 sw, 2 time, 3 aux, 4..7 ch1..ch4.
trig_en_i  in  8  per-source enable, same bit map (TRIG_EN).
ext_dly_i  in  g_DLY_WIDTH  external-trigger delay in clock cycles.
holdoff_i  in  g_HOLDOFF_WIDTH  minimum number of cycles between accepted triggers.
armed_i  in  1  acquisition FSM is in WAIT_TRIG.
acq_stop_i  in  1  abort pulse from CTL stop.
cnt_clr_i  in  1  clears both counters.
trig_o  out  1  qualified trigger pulse to the acquisition FSM.
trig_src_o  out  8  sources that caused the last accepted trigger.
trig_cnt_o  out  g_CNT_WIDTH  number of accepted triggers.
miss_cnt_o  out  g_CNT_WIDTH  number of missed triggers.
ext_dly_busy_o  out  1  external delay is running.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, delay counter idle.
- External delay path:
  - An ext pulse with trig_en_i[0]=1 and ext_dly_i=0 enters the request vector in the same cycle.
  - If ext_dly_i>0, the counter loads ext_dly_i on the next edge and ext_dly_busy_o goes 1. The delayed request is asserted in the cycle the counter equals 1, so the delay adds exactly ext_dly_i cycles.
  - ext_dly_i is captured at load; later changes do not affect a running delay.
  - An ext pulse arriving while the delay is busy is dropped. It increments miss_cnt_o only if armed_i=1.
- Request vector: req = (trig_src_i & trig_en_i with bit 0 masked) | (ext_delayed << 0). Disabled sources are ignored entirely.
- FSM states: IDLE, READY, HOLDOFF.
  - IDLE: move to READY when armed_i=1. A request seen in IDLE is ignored and not counted.
  - READY, |req=1: on the next edge, trig_o=1 for exactly 1 cycle, trig_src_o<=req (all simultaneous bits), and trig_cnt_o increments.
    - If holdoff_i=0, the FSM stays in READY.
    - Otherwise the holdoff counter loads holdoff_i and the FSM enters HOLDOFF.
  - READY, armed_i=0: go to IDLE.
  - HOLDOFF: the counter decrements each cycle. Any nonzero req increments miss_cnt_o by 1 per cycle. At counter==1, go to READY if armed_i=1, else IDLE. The holdoff always completes even if armed_i drops.
- Latency: source pulse at cycle N gives trig_o at N+1. Ext with delay D gives trig_o at N+1+D.
- acq_stop_i is synchronous and has priority over everything except reset:
  - FSM goes to IDLE, the delay is cancelled, ext_dly_busy_o=0.
  - trig_o is forced 0 that cycle.
  - Counters and trig_src_o are kept.
- Counters saturate at all-ones.
- cnt_clr_i zeroes both counters. If an increment coincides with the clear, the clear wins.
- trig_src_o holds its value until the next accepted trigger.
- Reset mid-delay or mid-holdoff returns to the reset state immediately.

Decomposition:
- Package fmc_adc_trig_pkg holds:
  - source bit index constants (c_TRIG_EXT=0 .. c_TRIG_CH4=7),
  - c_NB_TRIG_SRC=8,
  - the state enum t_trig_sched_state {IDLE, READY, HOLDOFF}.
- One sub-module, fmc_adc_trig_dly: the loadable external-delay counter with busy and fire outputs and a cancel input.

Test Plan:
- Dly 0, holdoff 0, armed, sw enabled: sw pulse at cycle 10 gives trig_o at 11, trig_src_o=0x02, trig_cnt_o=1.
- ext_dly_i=3, ext enabled: ext pulse at cycle 20 gives trig_o at 24 and ext_dly_busy_o high cycles 21..23. A second ext pulse at 22 gives miss_cnt_o=1 and no extra trigger.
- holdoff_i=100, sw pulses at 0, 50 and 150 give triggers from the 1st and 3rd pulses only, trig_cnt_o=2, miss_cnt_o=1.
- ch1 and ch3 pulses in the same cycle give a single trig_o with trig_src_o=0x50 and trig_cnt_o incremented by 1.
- Disarmed, or a disabled source pulsed: no trig_o, counters unchanged. acq_stop_i during a delay of 10 gives no trig_o afterwards and ext_dly_busy_o=0 on the next cycle.
- Counters preset near all-ones by 65540 triggers with holdoff 0 saturate at 0xFFFF. cnt_clr_i coinciding with a trigger gives trig_cnt_o=0.
